// File: rtl/rx.sv
// Serial-to-parallel link receiver: start bit plus `SIZE data bits LSB first,
// collected into a DEPTH-entry FIFO that exposes a valid/ready interface.
`ifndef SIZE
`define SIZE 8
`endif

module rx #(
    parameter int DEPTH    = 2,
    parameter int routerid = -1,
    parameter     port     = "unknown"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    output logic             channel_busy,
    output logic             rx_active,
    output logic [`SIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);
    localparam int W    = `SIZE;
    localparam int CW   = (W > 1) ? $clog2(W) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int NW   = PW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [W-2:0]  shift;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;

    logic          last;
    logic          full;
    logic          push;
    logic          pop;
    logic [W-1:0]  word;

    assign last  = (state == RECV) && (cnt == CW'(W - 1));
    assign word  = {serial_in, shift};
    assign full  = (count == NW'(DEPTH));
    assign pop   = out_valid && out_ready;
    // A pop in the completion cycle frees the slot, so a full FIFO still accepts.
    assign push  = last && (!full || pop);

    assign channel_busy = full;
    assign rx_active    = (state == RECV);
    assign out_valid    = (count != '0);
    assign out_data     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state <= RECV;
                        cnt   <= '0;
                    end
                end
                RECV: begin
                    if (last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        shift[cnt] <= serial_in;
                        cnt        <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (last && full && !pop) overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (routerid > -1 && reset && push)
            $display("router %d %s rx : %d", routerid, port, word);
    end
`endif

endmodule

// File: tb/tb_rx.sv
// Directed and random checks for the serial link receiver (DEPTH=2, 8-bit flits).
`ifndef SIZE
`define SIZE 8
`endif

module tb_rx;
    logic             clk;
    logic             reset;
    logic             serial_in;
    logic             channel_busy;
    logic             rx_active;
    logic [`SIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    rx #(.DEPTH(2), .routerid(-1), .port("tb")) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .channel_busy(channel_busy), .rx_active(rx_active),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ser;
        logic       rdy;
        logic       act;
        logic       vld;
        logic       busy;
        logic       chk_data;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic ser, input logic rdy);
        serial_in = ser;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic rdy_last);
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(w[i], (i == 7) ? rdy_last : 1'b0);
    endtask

    logic [7:0] sb [$];
    logic [7:0] txw;
    logic [7:0] a5;
    int         sent, txbit, gap, cyc;
    logic       txing, rdy_r, ser_r;

    initial begin
        reset = 1'b0; serial_in = 1'b0; out_ready = 1'b0;

        // Reset holds everything at zero regardless of line activity.
        for (int i = 0; i < 4; i++) begin
            serial_in = i[0];
            @(posedge clk); #1;
        end
        chk("rst_busy",  channel_busy, 0);
        chk("rst_act",   rx_active,    0);
        chk("rst_valid", out_valid,    0);
        chk("rst_data",  out_data,     0);
        chk("rst_ovf",   overflow,     0);
        serial_in = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("idle_act",   rx_active, 0);
        chk("idle_valid", out_valid, 0);

        // Single frame 0xA5 followed by a pop.
        a5 = 8'hA5;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++)
            tbl[i+1] = '{a5[i], 1'b0, (i != 7), (i == 7), 1'b0, (i == 7), 8'hA5};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].ser, tbl[i].rdy);
            chk($sformatf("v%0d_act", i),  rx_active,    tbl[i].act);
            chk($sformatf("v%0d_vld", i),  out_valid,    tbl[i].vld);
            chk($sformatf("v%0d_busy", i), channel_busy, tbl[i].busy);
            if (tbl[i].chk_data) chk($sformatf("v%0d_data", i), out_data, tbl[i].data);
        end

        // Zero-gap back-to-back frames fill the FIFO.
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        chk("b2b_busy",  channel_busy, 1);
        chk("b2b_valid", out_valid,    1);
        chk("b2b_head",  out_data,     8'h00);
        chk("b2b_ovf",   overflow,     0);
        step(1'b0, 1'b1);
        chk("pop1_busy", channel_busy, 0);
        chk("pop1_head", out_data,     8'hFF);
        step(1'b0, 1'b1);
        chk("pop2_valid", out_valid, 0);

        // Overflow: drop while full, then accept with a same-edge pop.
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h3C, 1'b0);
        chk("ovf_flag", overflow,     1);
        chk("ovf_busy", channel_busy, 1);
        chk("ovf_head", out_data,     8'h00);
        step(1'b0, 1'b0);
        chk("ovf_idle", rx_active, 0);
        send(8'h3C, 1'b1);
        chk("ovf2_flag", overflow,     1);
        chk("ovf2_busy", channel_busy, 1);
        chk("ovf2_head", out_data,     8'hFF);
        step(1'b0, 1'b1);
        chk("ovf2_next", out_data, 8'h3C);
        step(1'b0, 1'b1);
        chk("ovf2_empty", out_valid, 0);

        // Reset in the middle of a frame discards it.
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("mid_act_pre", rx_active, 1);
        reset = 1'b0;
        #1;
        chk("mid_act",   rx_active, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_ovf",   overflow,  0);
        serial_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b0, 1'b0);
        chk("mid_nopush", out_valid, 0);
        send(8'h81, 1'b0);
        chk("post_valid", out_valid, 1);
        chk("post_data",  out_data,  8'h81);
        step(1'b0, 1'b1);

        // Random traffic from a transmitter that honours channel_busy.
        sent = 0; txing = 1'b0; txbit = 0; gap = 0; cyc = 0; txw = '0;
        while ((sent < 1000 || txing || sb.size() != 0) && cyc < 60000) begin
            rdy_r = ($urandom_range(0, 2) != 0);
            ser_r = 1'b0;
            if (txing) begin
                ser_r = txw[txbit];
                if (txbit == 7) begin
                    txing = 1'b0;
                    gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                end
                txbit++;
            end else if (gap > 0) begin
                gap--;
            end else if (sent < 1000 && !channel_busy) begin
                ser_r = 1'b1;
                txw   = 8'($urandom_range(0, 255));
                txing = 1'b1;
                txbit = 0;
                sb.push_back(txw);
                sent++;
            end
            if (out_valid && rdy_r) begin
                if (sb.size() == 0) chk("rnd_spurious", 1, 0);
                else chk("rnd_data", out_data, sb.pop_front());
            end
            step(ser_r, rdy_r);
            cyc++;
        end
        if (cyc >= 60000) chk("rnd_timeout", cyc, 0);
        chk("rnd_sent",  sent,      1000);
        chk("rnd_left",  sb.size(), 0);
        chk("rnd_ovf",   overflow,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
